rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the single write port of the 4-entry register file between two producers: requester 0 (ALU writeback) and requester 1 (load/memory writeback).
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- The winning request is held in a one-entry output register that drives the register file's Write/DestAddr/DestData inputs. A pipeline stall freezes that register.
- Sits between the execute/memory stages and the register file, in the same clock domain.

Parameters:
- BITS, 16, data width of the write data and of the register file entries.
- ADDR_W, 2, destination address width (4 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 holds a write.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  BITS  requester 0 write data.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req1_valid  in  1  requester 1 holds a write.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  BITS  requester 1 write data.
- req1_ready  out  1  requester 1 transfer accepted this cycle.
- wr_stall  in  1  downstream hold; output register must not change.
- rf_write  out  1  register file write enable.
- rf_dest_addr  out  ADDR_W  register file destination address.
- rf_dest_data  out  BITS  register file write data.
- rf_grant_id  out  1  which requester produced the current rf_write.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n. All state clears immediately on rst_n low, independent of clk.
- Reset values: rf_write=0, rf_dest_addr=0, rf_dest_data=0, rf_grant_id=0, priority pointer=0 (requester 0 favoured), req0_ready=req1_ready=0 while rst_n low.
- Output register state: EMPTY (rf_write=0) or FULL (rf_write=1).
- Slot free = EMPTY or (FULL and !wr_stall). A FULL entry retires on every clock edge where wr_stall=0.
- Arbitration is combinational and evaluated only when the slot is free:
  - Only one requester valid: it wins.
  - Both valid: the requester named by the pointer wins.
- reqN_ready = slot free AND requester N wins. At most one ready is high per cycle.
- readyN never depends on validN of the other requester when it is alone.
- A transfer occurs when reqN_valid and reqN_ready are both high. At the next edge:
  - rf_write=1, rf_dest_addr/rf_dest_data/rf_grant_id are loaded from the winner.
  - The pointer moves to the other requester, but only when both requesters were valid. A lone grant leaves the pointer unchanged.
- Slot free and no valid requests: the register goes EMPTY at the next edge (rf_write=0).
- Latency: request accepted in cycle N → register file write committed at the edge ending cycle N+1 (one-cycle register stage). Full throughput: one write per cycle while wr_stall=0.
- wr_stall=1 with FULL: the output register and pointer hold; both readys are 0.
- wr_stall=1 with EMPTY: the slot is free and a request is accepted. The register becomes FULL and holds until the stall drops.
- Requesters must hold valid, addr and data stable until ready. The arbiter does not buffer more than one entry.
- Both requesters target the same address in consecutive grants: both writes are issued in grant order. No coalescing.
- Reset mid-operation: an in-flight FULL entry is discarded and rf_write drops to 0 asynchronously.

Optional Feature:
- Macro: RF_WR_ARB_CONFLICT_CNT_EN.
- When defined, the block adds output port conflict_cnt (8 bits). The counter:
  - increments on each cycle where both valids are high and the slot is free (a loser existed);
  - saturates at 255;
  - resets to 0 with rst_n.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-stream while FULL with addr=2, data=0xBEEF → rf_write drops to 0 immediately, readys=0. After release, the first lone req0 (addr=1, data=0x0011) is granted.
- Lone requester: req1_valid with addr=3, data=0x1234 for one cycle, no stall → req1_ready=1 same cycle. Next cycle rf_write=1, rf_dest_addr=3, rf_dest_data=0x1234, rf_grant_id=1. Pointer is still 0.
- Round-robin: both valid continuously, req0 (addr 0, 0xAAAA) and req1 (addr 1, 0x5555), no stall → grant order 0,1,0,1. rf_write stays high every cycle. With the optional feature, conflict_cnt counts 4 after 4 cycles.
- Stall hold: FULL with addr=2, data=0x00FF, wr_stall=1 for 3 cycles, both requests valid → outputs unchanged and readys=0 for 3 cycles. After the stall drops, the entry retires and the pointer-favoured requester is granted.
- Stall while EMPTY: wr_stall=1, req0 valid (addr 1, 0x0F0F) → req0_ready=1 once. The register holds 0x0F0F until the stall drops, and req0_ready stays 0 meanwhile.
- Same destination: req0 addr=2, 0x1111, then req1 addr=2, 0x2222 → two rf_write pulses, 0x1111 then 0x2222. Register 2 ends at 0x2222.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between two producers:
//   requester 0 (ALU writeback) and requester 1 (load/memory writeback).
//   Round-robin arbitration feeds a one-entry output register that drives the
//   register file. A downstream stall freezes that register.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/addr/data       requester N write request (held until ready)
//   reqN_ready                 requester N transfer accepted this cycle
//   wr_stall                   downstream hold, output register must not change
//   rf_write                   register file write enable (entry FULL)
//   rf_dest_addr/rf_dest_data  register file destination address / write data
//   rf_grant_id                requester that produced the current entry
//   conflict_cnt               (only with RF_WR_ARB_CONFLICT_CNT_EN) saturating
//                              count of cycles where a requester lost arbitration
//
// Optional feature macro: RF_WR_ARB_CONFLICT_CNT_EN
module rf_write_arbiter #(
  parameter int unsigned BITS   = 16,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [BITS-1:0]   req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [BITS-1:0]   req1_data,
  output logic              req1_ready,
  input  logic              wr_stall,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_dest_addr,
  output logic [BITS-1:0]   rf_dest_data,
  output logic              rf_grant_id
`ifdef RF_WR_ARB_CONFLICT_CNT_EN
  ,
  output logic [7:0]        conflict_cnt
`endif
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [BITS-1:0]     r_data, w_data_d;
  logic                r_gid, w_gid_d;
  logic                r_ptr, w_ptr_d;

  logic w_slot_free;
  logic w_both;
  logic w_win0;
  logic w_win1;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    w_slot_free = (r_state == StEmpty) || !wr_stall;
    w_both      = req0_valid && req1_valid;
    w_win0      = req0_valid && (!req1_valid || !r_ptr);
    w_win1      = req1_valid && (!req0_valid || r_ptr);
  end

  // Readys are forced low while reset is asserted.
  assign req0_ready = rst_n && w_slot_free && w_win0;
  assign req1_ready = rst_n && w_slot_free && w_win1;

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_data_d  = r_data;
    w_gid_d   = r_gid;
    w_ptr_d   = r_ptr;
    if (w_slot_free) begin
      if (w_win0 || w_win1) begin
        w_state_d = StFull;
        w_addr_d  = w_win1 ? req1_addr : req0_addr;
        w_data_d  = w_win1 ? req1_data : req0_data;
        w_gid_d   = w_win1;
        if (w_both) begin
          w_ptr_d = ~r_ptr;
        end
      end else begin
        // Entry retired with nothing to replace it; payload kept, write disabled.
        w_state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_addr  <= '0;
      r_data  <= '0;
      r_gid   <= 1'b0;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
      r_gid   <= w_gid_d;
      r_ptr   <= w_ptr_d;
    end
  end

  assign rf_write     = (r_state == StFull);
  assign rf_dest_addr = r_addr;
  assign rf_dest_data = r_data;
  assign rf_grant_id  = r_gid;

`ifdef RF_WR_ARB_CONFLICT_CNT_EN
  logic [7:0] r_cnt, w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_both && w_slot_free && (r_cnt != 8'hFF)) begin
      w_cnt_d = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign conflict_cnt = r_cnt;
`endif

endmodule
